axi4_rd_arbiter: RTL

- Shares one AXI4 read channel pair (AR + R) of the vector core's external memory port between N_REQ read requesters (vector load unit lanes, scalar fetch, etc.).
- Round-robin arbitration, one outstanding burst at a time; R beats are steered back to the granted requester only.
- Sits between the requesters and the m_axi_ar*/m_axi_r* signals of the core's AXI full interface.
- Counts beats against the granted length and flags length mismatches.

---
 rtl/riscv_v_axi_pkg.sv | 26 ++
 rtl/rr_prio_picker.sv | 44 ++++
 rtl/axi4_rd_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/riscv_v_axi_pkg.sv
// Shared AXI definitions for the vector core's external memory port arbiters.
// Contents:
//   rd_arb_state_t - read arbiter FSM states (IDLE, ADDR, DATA)
//   AXI_LEN_W      - width of the AXI4 burst length field (beats-1)
//   BEAT_CNT_W     - width of a beat counter able to hold a full 256-beat burst
//   BEAT_CNT_MAX   - saturation value of the beat counter
//   burst_beats()  - converts an AXI length field into a beat count
package riscv_v_axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } rd_arb_state_t;

    localparam int AXI_LEN_W  = 8;
    localparam int BEAT_CNT_W = AXI_LEN_W + 1;

    localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_MAX = '1;

    // AXI encodes a burst as beats-1; one extra bit keeps 256 representable.
    function automatic logic [BEAT_CNT_W-1:0] burst_beats(input logic [AXI_LEN_W-1:0] len);
        return {1'b0, len} + 1'b1;
    endfunction

endpackage

// File: rtl/rr_prio_picker.sv
// Round-robin priority picker, purely combinational.
// Scans req starting at rr_ptr and wrapping, so index rr_ptr has the highest
// priority. Shared between the read- and write-side arbiters.
// Ports:
//   req    - request vector
//   rr_ptr - index with the highest priority this cycle
//   grant  - one-hot grant (all zero when req is zero)
//   idx    - binary index of the granted bit (0 when req is zero)
module rr_prio_picker #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    // Position of the k-th candidate after rr_ptr, modulo N (N need not be a
    // power of two, so the wrap is explicit).
    function automatic logic [IDX_W-1:0] rot_pos(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) begin
            s = s - N;
        end
        return IDX_W'(s);
    endfunction

    // Walk candidates from lowest to highest priority so the last match wins;
    // this avoids a separate "found" flag.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[rot_pos(rr_ptr, k)]) begin
                grant                 = '0;
                grant[rot_pos(rr_ptr, k)] = 1'b1;
                idx                   = rot_pos(rr_ptr, k);
            end
        end
    end

endmodule

// File: rtl/axi4_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel pair (AR + R) between
// N_REQ requesters, with a single outstanding burst.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   req_valid/ready/addr/len  - per-requester burst requests (packed slices)
//   rsp_valid/ready           - per-requester R beat handshake, only the
//                               granted requester is ever addressed
//   rsp_data, rsp_last        - shared R beat payload
//   m_axi_ar*, m_axi_r*       - AXI4 master read address / data channels
//   busy                      - a burst is being issued or transferred
//   len_err                   - sticky: a burst's beat count disagreed with arlen
module axi4_rd_arbiter
    import riscv_v_axi_pkg::*;
#(
    parameter int N_REQ              = 4,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_REQ-1:0]                  req_valid,
    output logic [N_REQ-1:0]                  req_ready,
    input  logic [N_REQ*C_M_AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*AXI_LEN_W-1:0]        req_len,
    output logic [N_REQ-1:0]                  rsp_valid,
    input  logic [N_REQ-1:0]                  rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_data,
    output logic                              rsp_last,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [AXI_LEN_W-1:0]              m_axi_arlen,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic                              m_axi_rlast,
    output logic                              busy,
    output logic                              len_err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    rd_arb_state_t state_q, state_d;

    logic [IDX_W-1:0]              rr_ptr_q;
    logic [IDX_W-1:0]              rr_ptr_next;
    logic [IDX_W-1:0]              winner_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_LEN_W-1:0]          len_q;
    logic [BEAT_CNT_W-1:0]         beat_cnt_q;
    logic [BEAT_CNT_W-1:0]         beat_cnt_inc;
    logic [BEAT_CNT_W-1:0]         exp_beats;
    logic                          len_err_q;

    logic [N_REQ-1:0] pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic             any_req;
    logic             r_hs;

    rr_prio_picker #(
        .N (N_REQ)
    ) u_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .grant  (pick_grant),
        .idx    (pick_idx)
    );

    assign any_req      = |req_valid;
    assign r_hs         = m_axi_rvalid && m_axi_rready;
    assign beat_cnt_inc = (beat_cnt_q == BEAT_CNT_MAX) ? beat_cnt_q : beat_cnt_q + 1'b1;
    assign exp_beats    = burst_beats(len_q);
    assign rr_ptr_next  = (winner_q == IDX_W'(N_REQ - 1)) ? '0 : winner_q + 1'b1;

    // Next-state and handshake outputs. The R path is a pure pass-through to
    // the winner; req_ready is held off during reset so no request is consumed
    // by a cycle whose latch is about to be discarded.
    always_comb begin
        state_d       = state_q;
        req_ready     = '0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        rsp_valid     = '0;
        rsp_data      = '0;
        rsp_last      = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req && !rst) begin
                    req_ready = pick_grant;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                rsp_valid[winner_q] = m_axi_rvalid;
                m_axi_rready        = rsp_ready[winner_q];
                rsp_data            = m_axi_rdata;
                rsp_last            = m_axi_rlast;
                if (r_hs && m_axi_rlast) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, burst latches and beat accounting. rlast alone ends a burst; the
    // counter only feeds the length check, flagging both early and missing rlast.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            winner_q   <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        winner_q <= pick_idx;
                        addr_q   <= req_addr[int'(pick_idx) * C_M_AXI_ADDR_WIDTH +: C_M_AXI_ADDR_WIDTH];
                        len_q    <= req_len[int'(pick_idx) * AXI_LEN_W +: AXI_LEN_W];
                    end
                end
                ADDR: begin
                    if (m_axi_arready) begin
                        beat_cnt_q <= '0;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beat_cnt_q <= beat_cnt_inc;
                        if (m_axi_rlast) begin
                            if (beat_cnt_inc != exp_beats) begin
                                len_err_q <= 1'b1;
                            end
                            rr_ptr_q <= rr_ptr_next;
                        end else if (beat_cnt_inc >= exp_beats) begin
                            len_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign m_axi_araddr = addr_q;
    assign m_axi_arlen  = len_q;
    assign busy         = (state_q != IDLE);
    assign len_err      = len_err_q;

endmodule
